// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, states
// and datapath select codes.
package mc_pkg;

  localparam int STATE_BITS = 4;

  // IR[31:26] opcodes handled by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // IDLE must stay at 0 so reset and the debug port agree on "stopped"
  typedef enum logic [STATE_BITS-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier: one-hot instruction class plus an
// illegal flag for anything the controller does not sequence.
module mc_opcode_class
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_r,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_addi,
  output logic       is_beq,
  output logic       is_bne,
  output logic       is_j,
  output logic       illegal
);

  // Decode each supported opcode; illegal is the complement of all of them
  always_comb begin
    is_r    = (opcode == OP_RTYPE);
    is_lw   = (opcode == OP_LW);
    is_sw   = (opcode == OP_SW);
    is_addi = (opcode == OP_ADDI);
    is_beq  = (opcode == OP_BEQ);
    is_bne  = (opcode == OP_BNE);
    is_j    = (opcode == OP_J);
    illegal = ~(is_r | is_lw | is_sw | is_addi | is_beq | is_bne | is_j);
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multi-cycle MIPS datapath. All datapath controls
// are decoded from the state register; only the memory-handshake cycles
// and the DECODE/BRANCH states also look at mem_ready / the IR opcode.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_eq,
  output logic               pc_write_ne,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  state_t state, next_state;
  logic   is_r, is_lw, is_sw, is_addi, is_beq, is_bne, is_j, op_illegal;

  // The zero flag steers the datapath's PC-write gate, not the sequencing
  logic unused_zero;
  assign unused_zero = zero;

  mc_opcode_class u_class (
    .opcode  (opcode),
    .is_r    (is_r),
    .is_lw   (is_lw),
    .is_sw   (is_sw),
    .is_addi (is_addi),
    .is_beq  (is_beq),
    .is_bne  (is_bne),
    .is_j    (is_j),
    .illegal (op_illegal)
  );

  // State register; reset forces IDLE so mem_req drops without waiting for an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  assign state_o = STATE_W'(state);

  // Output decode and next-state selection
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    pc_src      = PC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    alu_op      = ALU_ADD;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    next_state  = S_IDLE;
    case (state)
      S_IDLE: begin
        next_state = run ? S_FETCH : S_IDLE;
      end
      S_FETCH: begin
        // PC+4 computed in parallel; IR/PC only commit on the ready cycle
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut
        alu_src_b  = SRCB_IMM2;
        illegal_op = op_illegal;
        if (is_lw || is_sw)  next_state = S_MEMADR;
        else if (is_r)       next_state = S_EXEC;
        else if (is_addi)    next_state = S_ADDIEX;
        else if (is_beq || is_bne) next_state = S_BRANCH;
        else if (is_j)       next_state = S_JUMP;
        else                 next_state = run ? S_FETCH : S_IDLE;
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = is_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        next_state = run ? S_FETCH : S_IDLE;
      end
      S_MEMWR: begin
        // A store retires in the cycle memory accepts it
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) next_state = run ? S_FETCH : S_IDLE;
        else           next_state = S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        next_state = run ? S_FETCH : S_IDLE;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = run ? S_FETCH : S_IDLE;
      end
      S_BRANCH: begin
        // IR is still stable here, so the opcode picks the branch sense
        alu_src_a   = 1'b1;
        alu_op      = ALU_SUB;
        pc_src      = PC_ALUOUT;
        pc_write_eq = is_beq;
        pc_write_ne = is_bne;
        instr_done  = 1'b1;
        next_state  = run ? S_FETCH : S_IDLE;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PC_JUMP;
        instr_done = 1'b1;
        next_state = run ? S_FETCH : S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// cycle by cycle against hand-written state/output vectors.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_eq, pc_write_ne;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;
  logic [3:0] state_o;

  int errors = 0;
  int checks = 0;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_eq(pc_write_eq),
    .pc_write_ne(pc_write_ne), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .instr_done(instr_done),
    .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // {mem_req,mem_we,iord,ir_write,pc_write,pc_write_eq,pc_write_ne,pc_src,
  //  alu_src_a,alu_src_b,alu_op,reg_dst,mem_to_reg,reg_write,instr_done,illegal_op}
  logic [18:0] ov;
  assign ov = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_eq, pc_write_ne,
               pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal_op};

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3, ST_MEMRD = 4'd4, ST_MEMWB = 4'd5, ST_MEMWR = 4'd6,
    ST_EXEC = 4'd7, ST_ALUWB = 4'd8, ST_ADDIEX = 4'd9, ST_ADDIWB = 4'd10,
    ST_BRANCH = 4'd11, ST_JUMP = 4'd12;

  localparam logic [18:0] O_ZERO    = 19'b0;
  localparam logic [18:0] O_FETCH_W = 19'b1_0_0_0_0_0_0_00_0_01_00_0_0_0_0_0;
  localparam logic [18:0] O_FETCH_R = 19'b1_0_0_1_1_0_0_00_0_01_00_0_0_0_0_0;
  localparam logic [18:0] O_DECODE  = 19'b0_0_0_0_0_0_0_00_0_11_00_0_0_0_0_0;
  localparam logic [18:0] O_DEC_ILL = 19'b0_0_0_0_0_0_0_00_0_11_00_0_0_0_0_1;
  localparam logic [18:0] O_MEMADR  = 19'b0_0_0_0_0_0_0_00_1_10_00_0_0_0_0_0;
  localparam logic [18:0] O_MEMRD   = 19'b1_0_1_0_0_0_0_00_0_00_00_0_0_0_0_0;
  localparam logic [18:0] O_MEMWB   = 19'b0_0_0_0_0_0_0_00_0_00_00_0_1_1_1_0;
  localparam logic [18:0] O_MEMWR_R = 19'b1_1_1_0_0_0_0_00_0_00_00_0_0_0_1_0;
  localparam logic [18:0] O_EXEC    = 19'b0_0_0_0_0_0_0_00_1_00_10_0_0_0_0_0;
  localparam logic [18:0] O_ALUWB   = 19'b0_0_0_0_0_0_0_00_0_00_00_1_0_1_1_0;
  localparam logic [18:0] O_ADDIWB  = 19'b0_0_0_0_0_0_0_00_0_00_00_0_0_1_1_0;
  localparam logic [18:0] O_BEQ     = 19'b0_0_0_0_0_1_0_01_1_00_01_0_0_0_1_0;
  localparam logic [18:0] O_BNE     = 19'b0_0_0_0_0_0_1_01_1_00_01_0_0_0_1_0;
  localparam logic [18:0] O_JUMP    = 19'b0_0_0_0_1_0_0_10_0_00_00_0_0_0_1_0;

  // Advance one clock; drive mem_ready for the new cycle, then settle
  task automatic cycle(input logic rdy);
    @(posedge clk);
    #1 mem_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (state_o !== ST_IDLE || ov !== O_ZERO) begin
      errors++;
      $display("FAIL reset_idle: state=%0d outs=%b expected state=0 outs=%b", state_o, ov, O_ZERO);
    end
    rst = 1'b0; run = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    checks++;
    if (state_o !== ST_FETCH || ov !== O_FETCH_W) begin
      errors++;
      $display("FAIL fetch_wait: state=%0d outs=%b expected state=1 outs=%b", state_o, ov, O_FETCH_W);
    end
    // Assert reset between edges; the memory request must drop immediately
    #3 rst = 1'b1;
    #1;
    checks++;
    if (state_o !== ST_IDLE || ov !== O_ZERO) begin
      errors++;
      $display("FAIL reset_async: state=%0d outs=%b expected state=0 outs=%b", state_o, ov, O_ZERO);
    end
    #1 rst = 1'b0;
    cycle(1'b0);
    checks++;
    if (state_o !== ST_FETCH) begin
      errors++;
      $display("FAIL reset_restart: state=%0d expected 1", state_o);
    end
    // Return to IDLE with run high so the next task starts with a fetch
    #3 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic test_rtype();
    logic [3:0]  es [4] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_ALUWB};
    logic [18:0] eo [4] = '{O_FETCH_R, O_DECODE, O_EXEC, O_ALUWB};
    int dones = 0;
    opcode = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1);
      dones += int'(instr_done);
      checks++;
      if (state_o !== es[i] || ov !== eo[i]) begin
        errors++;
        $display("FAIL rtype c%0d: state=%0d outs=%b expected state=%0d outs=%b", i+1, state_o, ov, es[i], eo[i]);
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL rtype_done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  es [7] = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMRD, ST_MEMRD, ST_MEMWB};
    logic [18:0] eo [7] = '{O_FETCH_R, O_DECODE, O_MEMADR, O_MEMRD, O_MEMRD, O_MEMRD, O_MEMWB};
    logic        rd [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'b100011;
    for (int i = 0; i < 7; i++) begin
      cycle(rd[i]);
      checks++;
      if (state_o !== es[i] || ov !== eo[i]) begin
        errors++;
        $display("FAIL lw c%0d: state=%0d outs=%b expected state=%0d outs=%b", i+1, state_o, ov, es[i], eo[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [3:0]  es [4] = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWR};
    logic [18:0] eo [4] = '{O_FETCH_R, O_DECODE, O_MEMADR, O_MEMWR_R};
    int writes = 0;
    opcode = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1);
      writes += int'(reg_write);
      checks++;
      if (state_o !== es[i] || ov !== eo[i]) begin
        errors++;
        $display("FAIL sw c%0d: state=%0d outs=%b expected state=%0d outs=%b", i+1, state_o, ov, es[i], eo[i]);
      end
    end
    checks++;
    if (writes !== 0) begin
      errors++;
      $display("FAIL sw_no_regwrite: got %0d writes expected 0", writes);
    end
  endtask

  task automatic test_addi();
    logic [3:0]  es [4] = '{ST_FETCH, ST_DECODE, ST_ADDIEX, ST_ADDIWB};
    logic [18:0] eo [4] = '{O_FETCH_R, O_DECODE, O_MEMADR, O_ADDIWB};
    opcode = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1);
      checks++;
      if (state_o !== es[i] || ov !== eo[i]) begin
        errors++;
        $display("FAIL addi c%0d: state=%0d outs=%b expected state=%0d outs=%b", i+1, state_o, ov, es[i], eo[i]);
      end
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0]  ops [3] = '{6'b000100, 6'b000101, 6'b000010};
    logic [3:0]  est [3] = '{ST_BRANCH, ST_BRANCH, ST_JUMP};
    logic [18:0] eov [3] = '{O_BEQ, O_BNE, O_JUMP};
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      cycle(1'b1);
      cycle(1'b1);
      checks++;
      if (state_o !== ST_DECODE || ov !== O_DECODE) begin
        errors++;
        $display("FAIL br%0d_decode: state=%0d outs=%b expected state=2 outs=%b", k, state_o, ov, O_DECODE);
      end
      cycle(1'b1);
      checks++;
      if (state_o !== est[k] || ov !== eov[k]) begin
        errors++;
        $display("FAIL br%0d_exec: state=%0d outs=%b expected state=%0d outs=%b", k, state_o, ov, est[k], eov[k]);
      end
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111;
    cycle(1'b1);
    cycle(1'b0);
    checks++;
    if (state_o !== ST_DECODE || ov !== O_DEC_ILL) begin
      errors++;
      $display("FAIL illegal_pulse1: state=%0d outs=%b expected state=2 outs=%b", state_o, ov, O_DEC_ILL);
    end
    cycle(1'b1);
    checks++;
    if (state_o !== ST_FETCH || ov !== O_FETCH_R) begin
      errors++;
      $display("FAIL illegal_refetch: state=%0d outs=%b expected state=1 outs=%b", state_o, ov, O_FETCH_R);
    end
    cycle(1'b0);
    checks++;
    if (state_o !== ST_DECODE || ov !== O_DEC_ILL) begin
      errors++;
      $display("FAIL illegal_pulse2: state=%0d outs=%b expected state=2 outs=%b", state_o, ov, O_DEC_ILL);
    end
    run = 1'b0;
    cycle(1'b1);
    checks++;
    if (state_o !== ST_IDLE || ov !== O_ZERO) begin
      errors++;
      $display("FAIL illegal_to_idle: state=%0d outs=%b expected state=0 outs=%b", state_o, ov, O_ZERO);
    end
    cycle(1'b1);
    checks++;
    if (state_o !== ST_IDLE || ov !== O_ZERO) begin
      errors++;
      $display("FAIL idle_hold: state=%0d outs=%b expected state=0 outs=%b", state_o, ov, O_ZERO);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_addi();
    test_branch_jump();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
